// File: rtl/video_timing_gen_if.sv
// Video timing bundle: pixel enable, screen offsets and core RGB in; counters,
// blanking, syncs, DE, registered RGB and strobes out.
interface video_timing_gen_if #(
    parameter int HW    = 9,
    parameter int VW    = 9,
    parameter int RGB_W = 12
);
    logic             ce_pix;
    logic [4:0]       hoffs;
    logic [3:0]       voffs;
    logic [RGB_W-1:0] rgb_in;
    logic [HW-1:0]    hpos;
    logic [VW-1:0]    vpos;
    logic             hblank;
    logic             vblank;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [RGB_W-1:0] rgb_out;
    logic             line_start;
    logic             frame_start;
    logic             vblank_start;

    // master: the timing generator; slave: the core / video output side
    modport master (
        input  ce_pix, hoffs, voffs, rgb_in,
        output hpos, vpos, hblank, vblank, hsync, vsync, de, rgb_out,
               line_start, frame_start, vblank_start
    );
    modport slave (
        output ce_pix, hoffs, voffs, rgb_in,
        input  hpos, vpos, hblank, vblank, hsync, vsync, de, rgb_out,
               line_start, frame_start, vblank_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: H/V counters, blanking, syncs with
// frame-latched offsets, DE, frame/line strobes and a blanked RGB register.
module video_timing_gen #(
    parameter int HW           = 9,
    parameter int VW           = 9,
    parameter int RGB_W        = 12,
    parameter int H_TOTAL      = 384,
    parameter int H_ACT_START  = 24,
    parameter int H_ACT_END    = 280,
    parameter int H_SYNC_START = 312,
    parameter int H_SYNC_W     = 32,
    parameter int H_OFFS_STEP  = 2,
    parameter int V_TOTAL      = 263,
    parameter int V_ACT_START  = 0,
    parameter int V_ACT_END    = 224,
    parameter int V_SYNC_START = 232,
    parameter int V_SYNC_W     = 6,
    parameter int V_OFFS_STEP  = 1
) (
    input  logic               clk_sys,
    input  logic               reset,
    video_timing_gen_if.master vid
);
    localparam int OW = ((HW > VW) ? HW : VW) + 4;
    typedef logic [OW-1:0] ow_t;

    generate
        if (H_TOTAL > (1 << HW)) begin : g_chk_htot
            $error("H_TOTAL does not fit in HW bits");
        end
        if (V_TOTAL > (1 << VW)) begin : g_chk_vtot
            $error("V_TOTAL does not fit in VW bits");
        end
        if (H_ACT_END > H_TOTAL) begin : g_chk_hact
            $error("H_ACT_END exceeds H_TOTAL");
        end
        if (V_ACT_END > V_TOTAL) begin : g_chk_vact
            $error("V_ACT_END exceeds V_TOTAL");
        end
        // The sync-base wrap below corrects by at most one period.
        if (H_SYNC_START >= H_TOTAL || 16 * H_OFFS_STEP > H_TOTAL ||
            V_SYNC_START >= V_TOTAL || 8 * V_OFFS_STEP > V_TOTAL || V_SYNC_W < 1) begin : g_chk_sync
            $error("sync start/offset range must stay within one period");
        end
    endgenerate

    logic [HW-1:0]    hcnt, hcnt_nx;
    logic [VW-1:0]    vcnt, vcnt_nx;
    logic [4:0]       hoffs_l, hoffs_e;
    logic [3:0]       voffs_l, voffs_e;
    logic             hblank, vblank, hsync, vsync, de;
    logic [RGB_W-1:0] rgb_out;
    logic             line_start, frame_start, vblank_start;
    ow_t              hn, vn, hs_raw, vs_raw, hs_b, vs_b, hd, vd;
    logic             h_wrap, frame_nx, hb_nx, vb_nx, hs_act, vs_act;

    always_comb begin
        h_wrap  = (ow_t'(hcnt) == ow_t'(H_TOTAL - 1));
        hcnt_nx = h_wrap ? '0 : hcnt + HW'(1);
        vcnt_nx = vcnt;
        if (h_wrap)
            vcnt_nx = (ow_t'(vcnt) == ow_t'(V_TOTAL - 1)) ? '0 : vcnt + VW'(1);
        hn       = ow_t'(hcnt_nx);
        vn       = ow_t'(vcnt_nx);
        frame_nx = (hn == '0) && (vn == '0);
        // The edge that starts a frame already decodes with the freshly sampled offsets.
        hoffs_e  = frame_nx ? vid.hoffs : hoffs_l;
        voffs_e  = frame_nx ? vid.voffs : voffs_l;
        hs_raw   = ow_t'(H_SYNC_START) + ow_t'(H_OFFS_STEP) * {{(OW-5){hoffs_e[4]}}, hoffs_e};
        vs_raw   = ow_t'(V_SYNC_START) + ow_t'(V_OFFS_STEP) * {{(OW-4){voffs_e[3]}}, voffs_e};
        if (hs_raw[OW-1])                   hs_b = hs_raw + ow_t'(H_TOTAL);
        else if (hs_raw >= ow_t'(H_TOTAL))  hs_b = hs_raw - ow_t'(H_TOTAL);
        else                                hs_b = hs_raw;
        if (vs_raw[OW-1])                   vs_b = vs_raw + ow_t'(V_TOTAL);
        else if (vs_raw >= ow_t'(V_TOTAL))  vs_b = vs_raw - ow_t'(V_TOTAL);
        else                                vs_b = vs_raw;
        // Distances past the sync bases, modulo the period, so both windows may wrap.
        hd = (hn >= hs_b) ? hn - hs_b : hn + ow_t'(H_TOTAL) - hs_b;
        vd = (vn >= vs_b) ? vn - vs_b : vn + ow_t'(V_TOTAL) - vs_b;
        hs_act = (hd < ow_t'(H_SYNC_W));
        vs_act = ((vd == '0) && (hn >= hs_b)) ||
                 ((vd != '0) && (vd < ow_t'(V_SYNC_W))) ||
                 ((vd == ow_t'(V_SYNC_W)) && (hn < hs_b));
        hb_nx = (hn < ow_t'(H_ACT_START)) || (hn >= ow_t'(H_ACT_END));
        vb_nx = (vn < ow_t'(V_ACT_START)) || (vn >= ow_t'(V_ACT_END));
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hcnt         <= '0;
            vcnt         <= '0;
            hoffs_l      <= '0;
            voffs_l      <= '0;
            hblank       <= 1'b1;
            vblank       <= 1'b1;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            de           <= 1'b0;
            rgb_out      <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            if (vid.ce_pix) begin
                hcnt         <= hcnt_nx;
                vcnt         <= vcnt_nx;
                hblank       <= hb_nx;
                vblank       <= vb_nx;
                de           <= ~hb_nx & ~vb_nx;
                hsync        <= ~hs_act;
                vsync        <= ~vs_act;
                rgb_out      <= (hblank | vblank) ? '0 : vid.rgb_in;
                line_start   <= (hn == '0);
                frame_start  <= frame_nx;
                vblank_start <= (hn == '0) && (vn == ow_t'(V_ACT_END));
                if (frame_nx) begin
                    hoffs_l <= vid.hoffs;
                    voffs_l <= vid.voffs;
                end
            end
        end
    end

    assign vid.hpos         = hcnt - HW'(H_ACT_START);
    assign vid.vpos         = vcnt - VW'(V_ACT_START);
    assign vid.hblank       = hblank;
    assign vid.vblank       = vblank;
    assign vid.hsync        = hsync;
    assign vid.vsync        = vsync;
    assign vid.de           = de;
    assign vid.rgb_out      = rgb_out;
    assign vid.line_start   = line_start;
    assign vid.frame_start  = frame_start;
    assign vid.vblank_start = vblank_start;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced 64x24 raster so several frames fit
// in a short run; a position-based model feeds an expected queue per ce edge.
module tb_video_timing_gen;
  localparam int HW = 7, VW = 5, RGB_W = HW + VW;
  localparam int H_TOTAL = 64, H_ACT_START = 6, H_ACT_END = 46;
  localparam int H_SYNC_START = 50, H_SYNC_W = 6, H_OFFS_STEP = 2;
  localparam int V_TOTAL = 24, V_ACT_START = 2, V_ACT_END = 18;
  localparam int V_SYNC_START = 20, V_SYNC_W = 3, V_OFFS_STEP = 1;
  localparam int FRAME = H_TOTAL * V_TOTAL;
  localparam int VEC_W = HW + VW + 5 + RGB_W + 3;
  // hpos = -6 mod 128, vpos = -2 mod 32, blanks/syncs high, de/rgb/strobes low
  localparam logic [VEC_W-1:0] RESET_VEC =
    {7'd122, 5'd30, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 3'b000};

  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  always #5 clk_sys = ~clk_sys;

  video_timing_gen_if #(.HW(HW), .VW(VW), .RGB_W(RGB_W)) vif ();

  video_timing_gen #(
    .HW(HW), .VW(VW), .RGB_W(RGB_W),
    .H_TOTAL(H_TOTAL), .H_ACT_START(H_ACT_START), .H_ACT_END(H_ACT_END),
    .H_SYNC_START(H_SYNC_START), .H_SYNC_W(H_SYNC_W), .H_OFFS_STEP(H_OFFS_STEP),
    .V_TOTAL(V_TOTAL), .V_ACT_START(V_ACT_START), .V_ACT_END(V_ACT_END),
    .V_SYNC_START(V_SYNC_START), .V_SYNC_W(V_SYNC_W), .V_OFFS_STEP(V_OFFS_STEP)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .vid(vif)
  );

  logic [VEC_W-1:0] exp_q[$];
  int checks = 0, errors = 0;
  int m_p = 0, m_ho = 0, m_vo = 0, hoffs_i = 0, voffs_i = 0;
  int idle_min = 0, idle_max = 1;
  int cnt_ce, cnt_ls, cnt_de, cnt_vbs, cnt_hslow, cnt_vslow, fs_at;
  int hs_fall_h, vs_fall_v, vs_fall_h;

  task automatic check(input string name, input logic [VEC_W-1:0] act,
                       input logic [VEC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] pack_dut();
    return {vif.hpos, vif.vpos, vif.hblank, vif.vblank, vif.hsync, vif.vsync,
            vif.de, vif.rgb_out, vif.line_start, vif.frame_start, vif.vblank_start};
  endfunction

  function automatic logic [VEC_W-1:0] model_vec(input int p, input int ho, input int vo,
                                                 input logic [RGB_W-1:0] rgb);
    int h, v, hs_b, vs_b, f;
    bit hb, vb, hs_n, vs_n;
    h    = p % H_TOTAL;
    v    = p / H_TOTAL;
    hs_b = (H_SYNC_START + H_OFFS_STEP * ho + 2 * H_TOTAL) % H_TOTAL;
    vs_b = (V_SYNC_START + V_OFFS_STEP * vo + 2 * V_TOTAL) % V_TOTAL;
    hb   = (h < H_ACT_START) || (h >= H_ACT_END);
    vb   = (v < V_ACT_START) || (v >= V_ACT_END);
    hs_n = ((h - hs_b + H_TOTAL) % H_TOTAL) >= H_SYNC_W;
    f    = vs_b * H_TOTAL + hs_b;
    vs_n = ((p - f + FRAME) % FRAME) >= V_SYNC_W * H_TOTAL;
    return {HW'(h - H_ACT_START), VW'(v - V_ACT_START), hb, vb, hs_n, vs_n,
            !hb && !vb, rgb, h == 0, p == 0, (h == 0) && (v == V_ACT_END)};
  endfunction

  task automatic set_offs(input int ho, input int vo);
    hoffs_i   = ho;
    voffs_i   = vo;
    vif.hoffs = 5'(ho);
    vif.voffs = 4'(vo);
  endtask

  // Drives one clk_sys cycle; returns on the following falling edge.
  task automatic do_clk(input bit ce);
    int hq, vq;
    bit act;
    logic [RGB_W-1:0] rgb;
    hq = m_p % H_TOTAL;
    vq = m_p / H_TOTAL;
    rgb = {VW'(vq - V_ACT_START), HW'(hq - H_ACT_START)};
    act = (hq >= H_ACT_START) && (hq < H_ACT_END) && (vq >= V_ACT_START) && (vq < V_ACT_END);
    vif.rgb_in = rgb;
    vif.ce_pix = ce;
    @(posedge clk_sys);
    if (ce && !reset) begin
      m_p = (m_p + 1) % FRAME;
      if (m_p == 0) begin
        m_ho = hoffs_i;
        m_vo = voffs_i;
      end
      exp_q.push_back(model_vec(m_p, m_ho, m_vo, act ? rgb : '0));
    end
    @(negedge clk_sys);
  endtask

  task automatic step_ce();
    repeat ($urandom_range(idle_min, idle_max)) do_clk(1'b0);
    do_clk(1'b1);
  endtask

  task automatic run_until_p(input int target, input string name);
    int n = 0;
    while (m_p != target && n < 2 * FRAME) begin
      step_ce();
      n++;
    end
    if (m_p != target) check(name, VEC_W'(m_p), VEC_W'(target));
  endtask

  task automatic run_to_frame_start();
    int n = 0;
    do begin
      step_ce();
      n++;
    end while (m_p != 0 && n < 2 * FRAME);
    if (m_p != 0) check("frame_start_timeout", VEC_W'(m_p), '0);
    #1;
  endtask

  task automatic clear_stats();
    cnt_ce = 0; cnt_ls = 0; cnt_de = 0; cnt_vbs = 0;
    cnt_hslow = 0; cnt_vslow = 0; fs_at = 0;
    hs_fall_h = -1; vs_fall_v = -1; vs_fall_h = -1;
  endtask

  // Monitor: pops one expectation per ce edge, checks hold/strobe clear otherwise.
  initial begin
    logic ce_q, rst_q, prev_hs, prev_vs;
    logic [VEC_W-1:0] act, e, last_exp;
    last_exp = RESET_VEC;
    prev_hs  = 1'b1;
    prev_vs  = 1'b1;
    forever begin
      @(posedge clk_sys);
      ce_q  = vif.ce_pix;
      rst_q = reset;
      @(negedge clk_sys);
      act = pack_dut();
      if (rst_q || reset) begin
        last_exp = RESET_VEC;
        prev_hs  = 1'b1;
        prev_vs  = 1'b1;
      end else if (ce_q) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", VEC_W'(1), '0);
        end else begin
          e = exp_q.pop_front();
          check("ce_edge", act, e);
          last_exp = e;
        end
        cnt_ce++;
        if (vif.line_start) cnt_ls++;
        if (vif.de) cnt_de++;
        if (vif.vblank_start) cnt_vbs++;
        if (!vif.hsync) cnt_hslow++;
        if (!vif.vsync) cnt_vslow++;
        if (vif.frame_start && fs_at == 0) fs_at = cnt_ce;
        if (prev_hs && !vif.hsync)
          hs_fall_h = (int'(vif.hpos) + H_ACT_START) % (1 << HW);
        if (prev_vs && !vif.vsync) begin
          vs_fall_v = (int'(vif.vpos) + V_ACT_START) % (1 << VW);
          vs_fall_h = (int'(vif.hpos) + H_ACT_START) % (1 << HW);
        end
        prev_hs = vif.hsync;
        prev_vs = vif.vsync;
      end else begin
        e = {last_exp[VEC_W-1:3], 3'b000};
        check("hold", act, e);
        last_exp = e;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vif.ce_pix = 1'b0;
    vif.rgb_in = '0;
    set_offs(0, 0);
    clear_stats();
    @(negedge clk_sys);
    #1 check("reset_values", pack_dut(), RESET_VEC);
    repeat (3) do_clk(1'b1);
    check("reset_ignores_ce", pack_dut(), RESET_VEC);
    reset = 1'b0;

    // Defaults, ce every 4th clk: one frame from reset, then one full period.
    idle_min = 3; idle_max = 3;
    clear_stats();
    run_to_frame_start();
    check("first_fs_ce", VEC_W'(fs_at), VEC_W'(FRAME));
    check("line_starts", VEC_W'(cnt_ls), VEC_W'(V_TOTAL));
    check("de_count", VEC_W'(cnt_de), VEC_W'(640));
    check("vblank_starts", VEC_W'(cnt_vbs), VEC_W'(1));
    check("hsync_low_cnt", VEC_W'(cnt_hslow), VEC_W'(144));
    check("vsync_low_cnt", VEC_W'(cnt_vslow), VEC_W'(192));
    check("hs_fall_default", VEC_W'(hs_fall_h), VEC_W'(50));
    check("vs_fall_line", VEC_W'(vs_fall_v), VEC_W'(20));
    check("vs_fall_h", VEC_W'(vs_fall_h), VEC_W'(50));
    clear_stats();
    run_to_frame_start();
    check("frame_period", VEC_W'(fs_at), VEC_W'(FRAME));

    // Offset extremes, including an hsync window that wraps the line end.
    idle_min = 0; idle_max = 1;
    set_offs(-16, 7);
    run_to_frame_start();
    clear_stats();
    run_to_frame_start();
    check("hs_fall_m16", VEC_W'(hs_fall_h), VEC_W'(18));
    check("hs_low_m16", VEC_W'(cnt_hslow), VEC_W'(144));
    check("vs_fall_p7", VEC_W'(vs_fall_v), VEC_W'(3));
    check("vs_fall_h_m16", VEC_W'(vs_fall_h), VEC_W'(18));
    check("vs_low_p7", VEC_W'(cnt_vslow), VEC_W'(192));
    set_offs(6, 0);
    run_to_frame_start();
    clear_stats();
    run_to_frame_start();
    check("hs_fall_wrap", VEC_W'(hs_fall_h), VEC_W'(62));
    check("hs_low_wrap", VEC_W'(cnt_hslow), VEC_W'(144));
    set_offs(15, -8);
    run_to_frame_start();
    clear_stats();
    run_to_frame_start();
    check("hs_fall_p15", VEC_W'(hs_fall_h), VEC_W'(16));
    check("vs_fall_m8", VEC_W'(vs_fall_v), VEC_W'(12));
    check("frame_period_offs", VEC_W'(fs_at), VEC_W'(FRAME));

    // Mid-frame offset change only lands at the next frame start.
    set_offs(0, 0);
    run_to_frame_start();
    run_until_p(10 * H_TOTAL, "reach_line10");
    set_offs(5, 0);
    clear_stats();
    run_until_p(20 * H_TOTAL, "reach_line20");
    #1 check("hoffs_deferred", VEC_W'(hs_fall_h), VEC_W'(50));
    run_to_frame_start();
    run_until_p(H_TOTAL, "reach_line1");
    #1 check("hoffs_applied", VEC_W'(hs_fall_h), VEC_W'(60));

    // ce_pix held low mid-line: the monitor checks every idle cycle.
    run_until_p(7 * H_TOTAL + 20, "reach_hold");
    repeat (50) do_clk(1'b0);

    // RGB pipeline around the start and end of an active line.
    run_until_p(5 * H_TOTAL + 6, "reach_rgb0");
    #1 check("rgb_first_blank", VEC_W'(vif.rgb_out), '0);
    run_until_p(5 * H_TOTAL + 7, "reach_rgb1");
    #1 check("rgb_first_active", VEC_W'(vif.rgb_out), VEC_W'(12'h180));
    run_until_p(5 * H_TOTAL + 8, "reach_rgb2");
    #1 check("rgb_second_active", VEC_W'(vif.rgb_out), VEC_W'(12'h181));
    run_until_p(5 * H_TOTAL + 46, "reach_rgb_last");
    #1 check("rgb_last_active", VEC_W'(vif.rgb_out), VEC_W'(12'h1A7));
    run_until_p(5 * H_TOTAL + 47, "reach_rgb_blank");
    #1 check("rgb_trailing_blank", VEC_W'(vif.rgb_out), '0);

    // Asynchronous reset mid-frame with non-zero offsets already latched.
    set_offs(3, -2);
    run_to_frame_start();
    run_until_p(12 * H_TOTAL + 40, "reach_reset_point");
    #2 reset = 1'b1;
    m_p = 0; m_ho = 0; m_vo = 0;
    #1 check("reset_async", pack_dut(), RESET_VEC);
    repeat (2) do_clk(1'b1);
    check("reset_held", pack_dut(), RESET_VEC);
    reset = 1'b0;
    clear_stats();
    run_to_frame_start();
    check("fs_after_reset", VEC_W'(fs_at), VEC_W'(FRAME));
    check("offs_cleared_by_reset", VEC_W'(hs_fall_h), VEC_W'(50));
    run_until_p(H_TOTAL, "reach_post_reset_line1");
    #1 check("offs_relatched", VEC_W'(hs_fall_h), VEC_W'(56));

    repeat (3) do_clk(1'b0);
    #1 check("queue_drained", VEC_W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
